// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and helpers for the alarm bank.
//   alarm_state_t : per-channel state (IDLE, RINGING, SNOOZED)
//   bcd_time_t    : packed 2-digit BCD {hour, min, sec}
//   bcd_inc       : BCD increment that wraps to 00 past a given limit
package alarm_pkg;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} alarm_state_t;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } bcd_time_t;

  // lim is the last valid value (8'h59 or 8'h23); the step after it is 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim)           return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// alarm_channel: one alarm channel -- editable BCD time, arm flag,
// IDLE/RINGING/SNOOZED state and a shared ring/snooze seconds timer.
//   clk, reset        : clock, synchronous active-high reset
//   tick              : one-cycle second pulse, cur holds the new second
//   cur               : current time of day (BCD)
//   up_sec/min/hour   : field increments, already qualified by channel select
//   arm_tgl           : invert armed, already qualified by channel select
//   snooze, dismiss   : bank-wide controls
//   ringing, armed    : channel status
//   atime             : stored alarm time
// Macro ALARM_SNOOZE_EN: when undefined the snooze path is removed and
// SNOOZED is never entered.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int TW         = 9
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      tick,
  input  bcd_time_t cur,
  input  logic      up_sec,
  input  logic      up_min,
  input  logic      up_hour,
  input  logic      arm_tgl,
  input  logic      snooze,
  input  logic      dismiss,
  output logic      ringing,
  output logic      armed,
  output bcd_time_t atime
);

  alarm_state_t  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  // Edit fields and arm flag; edits never touch the state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      atime <= '0;
      armed <= 1'b0;
    end else begin
      if (up_sec)  atime.sec  <= bcd_inc(atime.sec,  8'h59);
      if (up_min)  atime.min  <= bcd_inc(atime.min,  8'h59);
      if (up_hour) atime.hour <= bcd_inc(atime.hour, 8'h23);
      if (arm_tgl) armed <= ~armed;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Priority: dismiss > disarm > snooze > timer expiry > match.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (dismiss || (arm_tgl && armed)) begin
      state_d = IDLE;
      timer_d = '0;
    end
`ifdef ALARM_SNOOZE_EN
    else if (snooze && state_q == RINGING) begin
      state_d = SNOOZED;
      timer_d = TW'(SNOOZE_SEC);
    end
`endif
    else if (tick) begin
      case (state_q)
        RINGING: begin
          if (timer_q <= TW'(1)) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        SNOOZED: begin
          if (timer_q <= TW'(1)) begin
            state_d = RINGING;
            timer_d = TW'(RING_SEC);
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        default: begin
          // Only IDLE channels can be fired, so a match while active never reloads.
          if (armed && atime == cur) begin
            state_d = RINGING;
            timer_d = TW'(RING_SEC);
          end
        end
      endcase
    end
  end

`ifndef ALARM_SNOOZE_EN
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  assign ringing = (state_q == RINGING);

endmodule

// File: rtl/alarm_bank.sv
// alarm_bank: NUM_ALARMS independently editable/armable BCD alarms compared
// against the time of day on each sec_tick, with ring, snooze, auto-timeout.
//   clk, reset                 : clock, synchronous active-high reset
//   sec_tick                   : one-cycle second pulse
//   cur_hour/cur_min/cur_sec   : current time, BCD
//   sel                        : channel for edits, arm toggle and sel_* view
//   up_sec/up_min/up_hour      : increment a field of channel sel
//   arm_toggle                 : invert armed[sel]
//   snooze / dismiss           : act on all ringing (and snoozed) channels
//   ring, ring_id              : any channel ringing / lowest ringing index
//   armed                      : arm flags
//   sel_hour/sel_min/sel_sec   : alarm time of channel sel (combinational)
// Macro ALARM_SNOOZE_EN enables the snooze feature; default build omits it.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int IDW        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sec_tick,
  input  logic [7:0]            cur_hour,
  input  logic [7:0]            cur_min,
  input  logic [7:0]            cur_sec,
  input  logic [IDW-1:0]        sel,
  input  logic                  up_sec,
  input  logic                  up_min,
  input  logic                  up_hour,
  input  logic                  arm_toggle,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic                  ring,
  output logic [IDW-1:0]        ring_id,
  output logic [NUM_ALARMS-1:0] armed,
  output logic [7:0]            sel_hour,
  output logic [7:0]            sel_min,
  output logic [7:0]            sel_sec
);

`ifdef ALARM_SNOOZE_EN
  localparam int TMAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
`else
  localparam int TMAX = RING_SEC;
`endif
  localparam int TW = $clog2(TMAX + 1);

  bcd_time_t                   cur;
  bcd_time_t [NUM_ALARMS-1:0]  atime;
  logic      [NUM_ALARMS-1:0]  ringing;
  bcd_time_t                   sel_t;

  assign cur = '{hour: cur_hour, min: cur_min, sec: cur_sec};

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
    logic en;
    assign en = (sel == IDW'(g));

    alarm_channel #(
      .RING_SEC  (RING_SEC),
      .SNOOZE_SEC(SNOOZE_SEC),
      .TW        (TW)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .tick   (sec_tick),
      .cur    (cur),
      .up_sec (up_sec  & en),
      .up_min (up_min  & en),
      .up_hour(up_hour & en),
      .arm_tgl(arm_toggle & en),
      .snooze (snooze),
      .dismiss(dismiss),
      .ringing(ringing[g]),
      .armed  (armed[g]),
      .atime  (atime[g])
    );
  end

  // Outputs derive only from channel state flops, so they follow the tick by one cycle.
  assign ring = |ringing;

  // Walk high to low so the lowest ringing index is the last write.
  always_comb begin
    ring_id = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (ringing[i]) ring_id = IDW'(i);
  end

  always_comb begin
    sel_t = '0;
    for (int i = 0; i < NUM_ALARMS; i++)
      if (sel == IDW'(i)) sel_t = atime[i];
  end

  assign sel_hour = sel_t.hour;
  assign sel_min  = sel_t.min;
  assign sel_sec  = sel_t.sec;

endmodule
